// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
//   Read-port bundle between a synchronous FIFO and the UART transmitter
//   that drains it.
//
//   Signals
//     fifo_read_e  one-cycle read strobe issued by the consumer
//     fifo_data    FIFO data_out; valid in the cycle after fifo_read_e
//     fifo_empty   FIFO empty flag
//
//   Modports
//     master  the consumer (fifo_uart_tx): drives fifo_read_e
//     slave   the FIFO: drives fifo_data and fifo_empty
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_read_e;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;

  modport master (
    output fifo_read_e,
    input  fifo_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_read_e,
    output fifo_data,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   Drains a synchronous FIFO one word at a time and serialises each word as
//   an asynchronous frame on tx: start bit (0), DATA_W data bits LSB first,
//   optional parity bit, then STOP_BITS stop bits (1).
//
//   Parameters
//     DATA_W        data bits per frame (= FIFO word width)
//     CLKS_PER_BIT  clk cycles per serial bit, >= 2
//     STOP_BITS     1 or 2
//     PARITY_EN     1 inserts a parity bit after the data bits
//     PARITY_ODD    0 = even parity (XOR of data), 1 = odd parity
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous, active-low reset
//     tx_en      permission to start new frames (sampled only in IDLE)
//     fifo       FIFO read port (master side: read strobe out, data/empty in)
//     tx         registered serial output, idles high
//     busy       high whenever the FSM is not in IDLE
//     byte_done  one-cycle pulse in the final stop-bit cycle of each frame
//
//   Sequence: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP.
//   FETCH pulses the read strobe, LOAD captures the word that the FIFO
//   presents one cycle later, so the start bit begins three cycles after
//   IDLE sees work available.
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // One cycle before the bit boundary: used to register byte_done so that
  // it lines up with the last stop cycle rather than trailing it.
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  baud_cnt_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic              stop_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              parity_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              byte_done_reg;
  logic              read_e_reg;
  logic              baud_last;
  logic              baud_pre;

  assign baud_last  = (baud_cnt_reg == BAUD_LAST);
  assign baud_pre   = (baud_cnt_reg == BAUD_PRE);
  // The next data bit is always taken from the shifted value so that the
  // tx register and the shift register advance together at a bit boundary.
  assign shift_next = shift_reg >> 1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      byte_done_reg <= 1'b0;
      read_e_reg    <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them.
      read_e_reg    <= 1'b0;
      byte_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          // The empty flag is only looked at here, so a frame is never
          // started from an empty FIFO and late flag changes are harmless.
          if (tx_en && !fifo.fifo_empty) begin
            state_reg  <= FETCH;
            read_e_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end

        FETCH: begin
          state_reg <= LOAD;
        end

        LOAD: begin
          shift_reg    <= fifo.fifo_data;
          parity_reg   <= (PARITY_ODD != 0) ? ~(^fifo.fifo_data) : (^fifo.fifo_data);
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b0;
          state_reg    <= START;
        end

        START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_reg    <= parity_reg;
                state_reg <= PARITY;
              end else begin
                tx_reg       <= 1'b1;
                stop_idx_reg <= 1'b0;
                state_reg    <= STOP;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= shift_next;
              tx_reg      <= shift_next[0];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        PARITY: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            stop_idx_reg <= 1'b0;
            state_reg    <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          tx_reg <= 1'b1;
          if (baud_pre && (stop_idx_reg == STOP_LAST)) begin
            byte_done_reg <= 1'b1;
          end
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (stop_idx_reg == STOP_LAST) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              stop_idx_reg <= stop_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign fifo.fifo_read_e = read_e_reg;
  assign tx               = tx_reg;
  assign busy             = busy_reg;
  assign byte_done        = byte_done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Two transmitter instances share clk/reset:
//     unit 0: 8N1, CLKS_PER_BIT=4
//     unit 1: 8 data, odd parity, 2 stop bits, CLKS_PER_BIT=4
//   Each unit drains a small behavioural FIFO. Stimulus pushes words into
//   the FIFO and, for words that must appear on the line, into an expected
//   queue. A per-unit serial decoder watches tx, checks framing, timing and
//   byte_done, and pops/compares the expected queue at the end of each frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic en_w   [2];
  logic tx_w   [2];
  logic busy_w [2];
  logic done_w [2];
  logic re_w   [2];
  logic emp_w  [2];

  // Behavioural FIFOs
  logic [7:0] mem [2][64];
  int wr_ptr [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};

  // Scoreboard and decoder state visible to the stimulus
  logic [7:0] exp_q [2][$];
  int  reads    [2] = '{0, 0};
  int  frames   [2] = '{0, 0};
  int  mon_pos  [2] = '{-1, -1};
  bit  mon_in   [2] = '{0, 0};
  logic par_seen [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input int inst, input string name,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unit%0d %s actual=%0h expected=%0h t=%0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    localparam int PEN   = (gi == 1) ? 1 : 0;
    localparam int ODD   = (gi == 1) ? 1 : 0;
    localparam int STOPN = (gi == 1) ? 2 : 1;
    localparam int FLEN  = (1 + 8 + PEN + STOPN) * CPB;

    fifo_uart_tx_if #(.DATA_W(8)) u_if ();

    fifo_uart_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (STOPN),
      .PARITY_EN    (PEN),
      .PARITY_ODD   (ODD)
    ) dut (
      .clk       (clk),
      .reset     (rstn),
      .tx_en     (en_w[gi]),
      .fifo      (u_if.master),
      .tx        (tx_w[gi]),
      .busy      (busy_w[gi]),
      .byte_done (done_w[gi])
    );

    assign u_if.fifo_empty = (wr_ptr[gi] == rd_ptr[gi]);
    assign re_w[gi]        = u_if.fifo_read_e;
    assign emp_w[gi]       = u_if.fifo_empty;

    // FIFO read port: data appears the cycle after the strobe
    always @(posedge clk) begin
      if (u_if.fifo_read_e && (wr_ptr[gi] != rd_ptr[gi])) begin
        u_if.fifo_data <= mem[gi][rd_ptr[gi] % 64];
        rd_ptr[gi]     <= rd_ptr[gi] + 1;
      end
    end

    // Serial decoder / monitor
    int   c       = 0;
    int   gap     = 0;
    int   fetch_t = -100;
    int   tnow    = 0;
    int   pos     = 0;
    int   ph      = 0;
    bit   gap_chk = 0;
    bit   prev_re = 0;
    logic bit_v;
    logic [7:0] dat;
    logic [7:0] e;

    always @(negedge clk) begin
      tnow++;
      if (!rstn) begin
        mon_in[gi]  = 0;
        mon_pos[gi] = -1;
        gap_chk     = 0;
        prev_re     = 0;
        gap         = 0;
      end else begin
        if (re_w[gi]) begin
          reads[gi]++;
          chk(!emp_w[gi], gi, "read_while_empty", emp_w[gi], 0);
          chk(!prev_re, gi, "read_pulse_width", prev_re, 0);
          fetch_t = tnow;
        end
        prev_re = re_w[gi];

        if (!mon_in[gi]) begin
          chk(!done_w[gi], gi, "byte_done_idle", done_w[gi], 0);
          if (!tx_w[gi]) begin
            mon_in[gi] = 1;
            c = 0;
            chk((tnow - fetch_t) == 2, gi, "start_latency", tnow - fetch_t, 2);
            if (gap_chk) chk(gap == 3, gi, "interframe_gap", gap, 3);
          end else begin
            gap++;
          end
        end

        if (mon_in[gi]) begin
          pos = c / CPB;
          ph  = c % CPB;
          mon_pos[gi] = pos;
          if (ph == 0) begin
            bit_v = tx_w[gi];
            chk(busy_w[gi] == 1'b1, gi, "busy_in_frame", busy_w[gi], 1);
            if (pos == 0) begin
              chk(tx_w[gi] == 1'b0, gi, "start_bit", tx_w[gi], 0);
            end else if (pos <= 8) begin
              dat[pos-1] = tx_w[gi];
            end else if (pos == 9 && PEN == 1) begin
              par_seen[gi] = tx_w[gi];
              chk(tx_w[gi] == ((ODD == 1) ? ~(^dat) : (^dat)), gi, "parity_bit",
                  tx_w[gi], (ODD == 1) ? ~(^dat) : (^dat));
            end else begin
              chk(tx_w[gi] == 1'b1, gi, "stop_bit", tx_w[gi], 1);
            end
          end else begin
            chk(tx_w[gi] == bit_v, gi, "bit_stable", tx_w[gi], bit_v);
          end
          chk(done_w[gi] == (c == FLEN - 1), gi, "byte_done_timing", done_w[gi], c == FLEN - 1);

          if (c == FLEN - 1) begin
            mon_in[gi] = 0;
            gap = 0;
            gap_chk = en_w[gi] && !emp_w[gi];
            frames[gi]++;
            chk(exp_q[gi].size() != 0, gi, "unexpected_frame", dat, 0);
            if (exp_q[gi].size() != 0) begin
              e = exp_q[gi].pop_front();
              chk(dat == e, gi, "frame_data", dat, e);
              $display("unit%0d frame %0d data=%02h expected=%02h", gi, frames[gi], dat, e);
            end
          end
          c++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit expect_it);
    mem[i][wr_ptr[i] % 64] = d;
    wr_ptr[i]++;
    if (expect_it) exp_q[i].push_back(d);
  endtask

  task automatic wait_frames(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (frames[i] < n && k < budget) begin
      step();
      k++;
    end
    chk(frames[i] >= n, i, "frame_wait", frames[i], n);
  endtask

  task automatic wait_pos(input int i, input int p, input int budget);
    int k;
    k = 0;
    while (!(mon_in[i] && mon_pos[i] == p) && k < budget) begin
      step();
      k++;
    end
    chk(mon_in[i] && mon_pos[i] == p, i, "bit_pos_wait", mon_pos[i], p);
  endtask

  logic [7:0] burst [8] = '{8'h01, 8'h09, 8'h07, 8'h03, 8'h04, 8'h06, 8'h08, 8'h0A};

  initial begin
    rstn     = 1'b0;
    en_w[0]  = 1'b1;
    en_w[1]  = 1'b0;
    push(0, 8'h09, 1'b1);

    // Reset held with work pending: quiet outputs, no pop
    repeat (2) begin
      step();
      chk(tx_w[0] == 1'b1, 0, "reset_tx", tx_w[0], 1);
      chk(busy_w[0] == 1'b0, 0, "reset_busy", busy_w[0], 0);
      chk(re_w[0] == 1'b0, 0, "reset_read_e", re_w[0], 0);
      chk(done_w[0] == 1'b0, 0, "reset_byte_done", done_w[0], 0);
      chk(rd_ptr[0] == 0, 0, "reset_no_pop", rd_ptr[0], 0);
    end
    rstn = 1'b1;

    // Single word 09
    wait_frames(0, 1, 80);
    chk(reads[0] == 1, 0, "single_reads", reads[0], 1);

    // Empty FIFO with tx_en high
    repeat (100) begin
      step();
      chk(re_w[0] == 1'b0 && tx_w[0] == 1'b1 && busy_w[0] == 1'b0, 0, "empty_idle",
          {re_w[0], tx_w[0], busy_w[0]}, 3'b010);
    end
    chk(reads[0] == 1, 0, "empty_reads", reads[0], 1);

    // Burst of 8
    en_w[0] = 1'b0;
    for (int i = 0; i < 8; i++) push(0, burst[i], 1'b1);
    step();
    en_w[0] = 1'b1;
    wait_frames(0, 9, 500);
    repeat (5) step();
    chk(reads[0] == 9, 0, "burst_reads", reads[0], 9);
    chk(wr_ptr[0] == rd_ptr[0], 0, "burst_fifo_empty", wr_ptr[0] - rd_ptr[0], 0);
    chk(exp_q[0].size() == 0, 0, "burst_all_seen", exp_q[0].size(), 0);

    // Parity unit: drop tx_en during data bit 3 of the first frame
    push(1, 8'h07, 1'b1);
    push(1, 8'h03, 1'b0);
    en_w[1] = 1'b1;
    wait_pos(1, 4, 60);
    en_w[1] = 1'b0;
    wait_frames(1, 1, 100);
    repeat (20) step();
    chk(reads[1] == 1, 1, "txen_drop_reads", reads[1], 1);
    chk(wr_ptr[1] - rd_ptr[1] == 1, 1, "txen_drop_fifo_level", wr_ptr[1] - rd_ptr[1], 1);
    chk(mem[1][rd_ptr[1] % 64] == 8'h03, 1, "txen_drop_fifo_head", mem[1][rd_ptr[1] % 64], 8'h03);
    chk(par_seen[1] == 1'b0, 1, "parity_07_odd", par_seen[1], 0);

    // Reset mid-frame during data bit 4 of 04, with 06 queued behind it
    push(0, 8'h04, 1'b0);
    wait_pos(0, 5, 60);
    rstn = 1'b0;
    push(0, 8'h06, 1'b1);
    step();
    chk(tx_w[0] == 1'b1, 0, "midreset_tx", tx_w[0], 1);
    chk(busy_w[0] == 1'b0, 0, "midreset_busy", busy_w[0], 0);
    step();
    rstn = 1'b1;
    wait_frames(0, 10, 100);
    repeat (10) step();
    chk(exp_q[0].size() == 0, 0, "after_reset_all_seen", exp_q[0].size(), 0);
    chk(reads[0] == 11, 0, "after_reset_reads", reads[0], 11);
    chk(frames[0] == 10, 0, "after_reset_frames", frames[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
